uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of FIFO depth (depth = 16 entries).
REQ-002 SHALL have parameter DW, default 8, data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1, write strobe from the producer.
REQ-006 SHALL have port wr_data, input, DW, byte to enqueue.
REQ-007 SHALL have port flush, input, 1, synchronous clear of FIFO contents.
REQ-008 SHALL have port full, output, 1, high when count equals depth.
REQ-009 SHALL have port empty, output, 1, high when count equals 0.
REQ-010 SHALL have port count, output, DEPTH_LOG2+1, entries held in storage, excluding the output register.
REQ-011 SHALL have port overflow, output, 1, one-cycle pulse when a write is dropped.
REQ-012 SHALL have port tx_valid, output, 1, byte offered to the UART transmitter.
REQ-013 SHALL have port tx_data, output, DW, byte offered to the transmitter.
REQ-014 SHALL have port tx_ready, input, 1, transmitter idle indication.

Function
REQ-015 SHALL store entries in a circular buffer with DEPTH_LOG2-bit read and write pointers that wrap from depth-1 to 0.
REQ-016 SHALL enqueue wr_data at the write pointer on wr_en when full is 0, and increment the write pointer.
REQ-017 SHALL drop a write when wr_en=1 and full=1, including when a pop occurs in the same cycle, and SHALL pulse overflow high on the following cycle for exactly one cycle.
REQ-018 SHALL run a 4-state FSM: IDLE, LOAD, OFFER, BUSY.
REQ-019 In IDLE, tx_valid SHALL be 0; when empty=0 the FSM SHALL go to LOAD on the next cycle.
REQ-020 LOAD SHALL last one cycle, copy the head entry into the tx_data register, increment the read pointer and decrement count (pop), then go to OFFER.
REQ-021 In OFFER, tx_valid SHALL be 1; on tx_valid && tx_ready, the FSM SHALL go to BUSY.
REQ-022 In BUSY, tx_valid SHALL be 0 and tx_data SHALL hold its value; the FSM SHALL first wait for tx_ready=0, then for tx_ready=1, then go to IDLE.
REQ-023 tx_data SHALL change only in LOAD, so the byte stays stable until the transmitter has latched and sent it.
REQ-024 On a simultaneous push and pop, count SHALL stay unchanged and both pointers SHALL advance.
REQ-025 count SHALL never exceed depth and never underflow; a pop SHALL occur only in LOAD with empty=0.
REQ-026 flush SHALL zero the pointers and count on the next edge and discard any same-cycle write.
REQ-027 flush SHALL NOT alter the FSM state or tx_data, so an in-flight byte completes its handshake.
REQ-028 Minimum spacing between transfers SHALL be IDLE+LOAD, i.e. 2 cycles after BUSY exits.

Reset
REQ-029 On rstn=0, at any time including mid-frame, the block SHALL set FSM=IDLE, pointers=0, count=0, tx_valid=0, tx_data=0, overflow=0, full=0, empty=1.
REQ-030 Reset SHALL be asynchronous to assert; operation SHALL resume on the first clk edge after rstn goes high.
REQ-031 Storage array contents SHALL need no reset.

Verification
REQ-032 Single byte: write 0x55 with tx_ready=1 -> LOAD, then tx_valid=1, tx_data=0x55; after acceptance tx_valid=0 until tx_ready falls and rises again.
REQ-033 Fill: 17 writes with tx_ready=0 -> the 1st byte is popped to tx_data; count=15 after 16 writes; full after the 17th; a further write -> overflow pulses once, count stays 16.
REQ-034 Order and wrap: 40 bytes 0x00..0x27 with a model transmitter (10-cycle busy) -> bytes emerge in order and pointers wrap twice.
REQ-035 Simultaneous: count=5, wr_en coincides with LOAD -> count stays 5.
REQ-036 Flush: count=8, OFFER holding 0xA5, flush pulse -> count=0, empty=1; 0xA5 is still delivered and no further bytes follow.
REQ-037 Reset mid-BUSY: rstn low for 2 cycles -> all outputs take REQ-029 values; after release with empty FIFO, tx_valid stays 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a registered valid/ready offer.
// A four-state handshake FSM pops one byte per frame and holds it until the transmitter finishes.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DW         = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DW-1:0]         wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_valid,
  output logic [DW-1:0]         tx_data,
  input  logic                  tx_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    OFFER = 2'd2,
    BUSY  = 2'd3
  } state_t;

  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  state_t                state;
  logic                  seen_low;
  logic                  push;
  logic                  pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A write is refused whenever storage is full, even if LOAD frees a slot this cycle.
  assign push = wr_en && !full && !flush;
  assign pop  = (state == LOAD) && !empty;

  // NOTE: storage carries no reset; it is only ever read at entries the pointers have written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Flush deliberately leaves this block alone so an in-flight byte completes its handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      seen_low <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_valid <= 1'b0;
          if (!empty) state <= LOAD;
        end
        LOAD: begin
          if (!empty) begin
            tx_data  <= mem[rptr];
            tx_valid <= 1'b1;
            state    <= OFFER;
          end else begin
            state <= IDLE;
          end
        end
        OFFER: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            seen_low <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // The transmitter drops ready while shifting the frame, then raises it when done.
          if (!seen_low) begin
            if (!tx_ready) seen_low <= 1'b1;
          end else if (tx_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rstn) count <= DEPTH_CNT);
  a_data_stable : assert property (@(posedge clk) disable iff (!rstn)
                                   (state != LOAD) |=> $stable(tx_data));

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo: a byte-queue scoreboard and a
// model transmitter check ordering, handshake timing, fill, overflow, flush and reset.
module tb_uart_tx_fifo;

  localparam int DL = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [DL:0]   count;
  logic          overflow;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;

  logic          man_ready;
  logic          xmtr_en;
  logic          xr;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            hs_count = 0;
  logic [DW-1:0] exp_q[$];

  assign tx_ready = xmtr_en ? xr : man_ready;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DL), .DW(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [DW-1:0] d, input bit expect_out);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_out) exp_q.push_back(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},    count,    0);
    check({tag, "_empty"},    empty,    1);
    check({tag, "_full"},     full,     0);
    check({tag, "_valid"},    tx_valid, 0);
    check({tag, "_data"},     tx_data,  0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      cyc();
      n++;
    end
    check({tag, "_drain_left"}, exp_q.size(), 0);
    repeat (15) cyc();
    check({tag, "_end_count"}, count,    0);
    check({tag, "_end_empty"}, empty,    1);
    check({tag, "_end_valid"}, tx_valid, 0);
  endtask

  // Scoreboard on the handshake, plus a transmitter that stays busy 10 cycles per byte.
  initial begin
    int busy_cnt = 0;
    bit hs;
    xr = 1'b1;
    forever begin
      @(negedge clk);
      hs = rstn && tx_valid && tx_ready;
      if (hs) begin
        hs_count++;
        check("tx_expected_any", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (hs) begin
        busy_cnt = 10;
        xr = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) xr = 1'b1;
      end
    end
  end

  initial begin
    int  idx;
    int  guard;
    int  hs0;
    bit  any_ovf;

    rstn = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
    man_ready = 1'b1; xmtr_en = 1'b0;
    cyc(); cyc();
    check_reset_outputs("rst");
    rstn = 1'b1;
    cyc();

    // Single byte through the full handshake.
    write_byte(8'h55, 1'b1);
    check("sb_count1", count, 1);
    check("sb_valid_a", tx_valid, 0);
    cyc();
    check("sb_valid_load", tx_valid, 0);
    cyc();
    check("sb_valid_offer", tx_valid, 1);
    check("sb_data", tx_data, 8'h55);
    check("sb_count0", count, 0);
    check("sb_empty", empty, 1);
    cyc();
    check("sb_valid_busy", tx_valid, 0);
    repeat (3) cyc();
    check("sb_busy_hold", tx_valid, 0);
    man_ready = 1'b0;
    cyc();
    check("sb_busy_low", tx_valid, 0);
    man_ready = 1'b1;
    cyc();
    check("sb_idle_valid", tx_valid, 0);
    check("sb_data_hold", tx_data, 8'h55);
    cyc();
    check("sb_idle_empty", tx_valid, 0);

    // Fill with the transmitter stalled, then overflow.
    man_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write_byte(DW'(i), 1'b1);
      if (i == 15) begin
        check("fill_count16w", count, 15);
        check("fill_notfull", full, 0);
      end
    end
    check("fill_count17w", count, 16);
    check("fill_full", full, 1);
    check("fill_valid", tx_valid, 1);
    check("fill_head", tx_data, 8'h00);
    write_byte(8'hEE, 1'b0);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 16);
    cyc();
    check("ovf_once", overflow, 0);
    check("ovf_count2", count, 16);
    xmtr_en = 1'b1;
    drain("fill");

    // Ordered stream 0x00..0x27, then random bytes with random gaps.
    idx = 0; guard = 0; any_ovf = 1'b0;
    while ((idx < 70 || exp_q.size() != 0) && guard < 6000) begin
      if (idx < 70 && !full && (idx < 40 || $urandom_range(0, 2) == 0)) begin
        wr_en   = 1'b1;
        wr_data = (idx < 40) ? DW'(idx) : DW'($urandom);
        exp_q.push_back(wr_data);
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      cyc();
      any_ovf |= overflow;
      guard++;
    end
    wr_en = 1'b0;
    check("rnd_no_overflow", any_ovf, 0);
    check("rnd_all_written", idx, 70);
    drain("rnd");

    // Push coinciding with LOAD keeps count.
    xmtr_en = 1'b0;
    man_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(DW'(8'h10 + i), 1'b1);
    check("sim_count_pre", count, 5);
    check("sim_head", tx_data, 8'h10);
    man_ready = 1'b1;
    cyc();
    man_ready = 1'b0;
    check("sim_busy", tx_valid, 0);
    cyc();
    man_ready = 1'b1;
    cyc();
    check("sim_idle_count", count, 5);
    cyc();
    check("sim_load_count", count, 5);
    write_byte(8'h20, 1'b1);
    man_ready = 1'b0;
    check("sim_count_post", count, 5);
    check("sim_valid", tx_valid, 1);
    check("sim_data", tx_data, 8'h11);

    // Reset asserted mid-BUSY.
    man_ready = 1'b1;
    cyc();
    check("rb_busy", tx_valid, 0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("rb");
    exp_q.delete();
    cyc(); cyc();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rb_post_valid", tx_valid, 0);
    end
    check("rb_post_empty", empty, 1);

    // Flush while a byte is offered.
    man_ready = 1'b0;
    write_byte(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) write_byte(DW'(8'hB0 + i), 1'b0);
    check("fl_count_pre", count, 8);
    check("fl_offer_data", tx_data, 8'hA5);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("fl_count", count, 0);
    check("fl_empty", empty, 1);
    check("fl_valid_kept", tx_valid, 1);
    check("fl_data_kept", tx_data, 8'hA5);
    hs0 = hs_count;
    xmtr_en = 1'b1;
    repeat (40) cyc();
    check("fl_one_byte", hs_count - hs0, 1);
    check("fl_q_empty", exp_q.size(), 0);
    check("fl_end_valid", tx_valid, 0);
    check("fl_end_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
